n64adv_blank_gen: RTL and testbench

- Output-side stage placed directly after the PPU top: consumes its final colour bus and the four registered sync lines (nVSYNC, nCLAMP, nHSYNC, nCSYNC).
- Measures line length per pixel strobe and tracks line and frame position.
- Generates nBLANK for the ADV712x from a programmable active window, or from raw syncs while timing is unlocked.
- Realigns colour and sync so all outputs share one latency.

---
 rtl/n64adv_blank_gen.sv | 121 ++++++++++++
 tb/tb_n64adv_blank_gen.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/n64adv_blank_gen.sv
// n64adv_blank_gen: measures line timing behind the PPU, realigns colour/sync and drives nBLANK.
// Build option N64ADV_BLANK_ZERO_EN: force VD_o to zero whenever nBLANK is low.
module n64adv_blank_gen #(
  parameter int color_width = 8,
  parameter int HCNT_W      = 12,
  parameter int VCNT_W      = 10
) (
  input  logic                     VCLK,
  input  logic                     nVRST,
  input  logic                     pix_en,
  input  logic [3:0]               Sync_i,
  input  logic [3*color_width-1:0] VD_i,
  input  logic [HCNT_W-1:0]        cfg_hstart,
  input  logic [HCNT_W-1:0]        cfg_hactive,
  input  logic [VCNT_W-1:0]        cfg_vstart,
  input  logic [VCNT_W-1:0]        cfg_vactive,
  output logic [3:0]               Sync_o,
  output logic [3*color_width-1:0] VD_o,
  output logic                     nBLANK,
  output logic                     hlocked,
  output logic [HCNT_W-1:0]        hlen
);

  localparam int CD_W = 3*color_width;

  // Sync bit positions within {nVSYNC,nCLAMP,nHSYNC,nCSYNC}
  localparam int NVS = 3;
  localparam int NHS = 1;

  logic [3:0]        sync_reg;
  logic [CD_W-1:0]   vd_reg;
  logic [HCNT_W-1:0] hcnt_reg;
  logic [VCNT_W-1:0] vcnt_reg;
  logic [1:0]        match_cnt_reg;
  logic [1:0]        match_cnt_next;

  logic              hs_fall;
  logic              vs_fall;
  logic              hcnt_sat;
  logic              vcnt_sat;
  logic              line_equal;
  logic [HCNT_W:0]   h_end;
  logic [VCNT_W:0]   v_end;
  logic              h_act;
  logic              v_act;
  logic              blank_next;

  always_comb begin
    hs_fall    = sync_reg[NHS] & ~Sync_i[NHS];
    vs_fall    = sync_reg[NVS] & ~Sync_i[NVS];
    hcnt_sat   = &hcnt_reg;
    vcnt_sat   = &vcnt_reg;
    // A saturated count means the line was too long to measure, so it never matches.
    line_equal = (hcnt_reg == hlen) && !hcnt_sat;

    match_cnt_next = 2'd0;
    if (line_equal) begin
      match_cnt_next = (match_cnt_reg == 2'd2) ? 2'd2 : match_cnt_reg + 2'd1;
    end

    // One extra bit keeps windows running past the counter maximum from wrapping.
    h_end = {1'b0, cfg_hstart} + {1'b0, cfg_hactive};
    v_end = {1'b0, cfg_vstart} + {1'b0, cfg_vactive};
    h_act = (hcnt_reg >= cfg_hstart) && ({1'b0, hcnt_reg} < h_end);
    v_act = (vcnt_reg >= cfg_vstart) && ({1'b0, vcnt_reg} < v_end);

    blank_next = hlocked ? (h_act & v_act) : (sync_reg[NHS] & sync_reg[NVS]);
  end

  // Stage 1: input capture, edge detection, counters and line measurement.
  always_ff @(posedge VCLK or negedge nVRST) begin
    if (!nVRST) begin
      sync_reg      <= '0;
      vd_reg        <= '0;
      hcnt_reg      <= '0;
      vcnt_reg      <= '0;
      match_cnt_reg <= '0;
      hlocked       <= 1'b0;
      hlen          <= '0;
    end else begin
      sync_reg <= Sync_i;
      vd_reg   <= VD_i;

      if (hs_fall) begin
        hcnt_reg <= '0;
      end else if (pix_en && !hcnt_sat) begin
        hcnt_reg <= hcnt_reg + 1'b1;
      end

      if (vs_fall) begin
        vcnt_reg <= '0;
      end else if (hs_fall && !vcnt_sat) begin
        vcnt_reg <= vcnt_reg + 1'b1;
      end

      if (hs_fall) begin
        hlen          <= hcnt_reg;
        match_cnt_reg <= match_cnt_next;
        hlocked       <= (match_cnt_next == 2'd2);
      end
    end
  end

  // Stage 2: output register, shared by colour, sync and nBLANK.
  always_ff @(posedge VCLK or negedge nVRST) begin
    if (!nVRST) begin
      Sync_o <= '0;
      VD_o   <= '0;
      nBLANK <= 1'b0;
    end else begin
      Sync_o <= sync_reg;
      nBLANK <= blank_next;
`ifdef N64ADV_BLANK_ZERO_EN
      VD_o   <= blank_next ? vd_reg : '0;
`else
      VD_o   <= vd_reg;
`endif
    end
  end

endmodule

// File: tb/tb_n64adv_blank_gen.sv
// Scoreboard bench for n64adv_blank_gen: directed lines with hand-chosen lengths, lock states and windows.
// Expected nBLANK is derived from the line position the bench itself drives.
module tb_n64adv_blank_gen;

  localparam int CW = 8;
  localparam int HW = 12;
  localparam int VW = 10;

  logic            VCLK = 1'b0;
  logic            nVRST = 1'b0;
  logic            pix_en = 1'b1;
  logic [3:0]      Sync_i = 4'hF;
  logic [3*CW-1:0] VD_i = '0;
  logic [HW-1:0]   cfg_hstart = '0;
  logic [HW-1:0]   cfg_hactive = '0;
  logic [VW-1:0]   cfg_vstart = '0;
  logic [VW-1:0]   cfg_vactive = '0;
  logic [3:0]      Sync_o;
  logic [3*CW-1:0] VD_o;
  logic            nBLANK;
  logic            hlocked;
  logic [HW-1:0]   hlen;

  n64adv_blank_gen #(.color_width(CW), .HCNT_W(HW), .VCNT_W(VW)) dut (
    .VCLK(VCLK), .nVRST(nVRST), .pix_en(pix_en), .Sync_i(Sync_i), .VD_i(VD_i),
    .cfg_hstart(cfg_hstart), .cfg_hactive(cfg_hactive),
    .cfg_vstart(cfg_vstart), .cfg_vactive(cfg_vactive),
    .Sync_o(Sync_o), .VD_o(VD_o), .nBLANK(nBLANK), .hlocked(hlocked), .hlen(hlen)
  );

  always #5 VCLK = ~VCLK;

  typedef struct {
    int            tag;
    logic [3:0]    sync;
    logic [3*CW-1:0] vd;
    logic          nb;
  } out_t;

  typedef struct {
    int          tag;
    logic [HW-1:0] hl;
    logic        lk;
  } st_t;

  out_t q_out[$];
  st_t  q_st[$];
  int   ec = 0;
  int   errors = 0;
  int   checks = 0;
  int   hs_c, ha_c, vst_c, va_c;

  initial forever begin
    @(posedge VCLK);
    ec++;
  end

  // Monitor: every entry is checked at the negedge of the cycle it was tagged for.
  initial begin
    out_t eo;
    st_t  es;
    forever begin
      @(negedge VCLK);
      while (q_out.size() > 0 && q_out[0].tag <= ec) begin
        eo = q_out.pop_front();
        checks++;
        if (eo.tag != ec || Sync_o !== eo.sync || VD_o !== eo.vd || nBLANK !== eo.nb) begin
          errors++;
          $display("FAIL out_align cyc=%0d tag=%0d got sync=%h vd=%h nBLANK=%b want sync=%h vd=%h nBLANK=%b",
                   ec, eo.tag, Sync_o, VD_o, nBLANK, eo.sync, eo.vd, eo.nb);
        end
      end
      while (q_st.size() > 0 && q_st[0].tag <= ec) begin
        es = q_st.pop_front();
        checks++;
        if (es.tag != ec || hlen !== es.hl || hlocked !== es.lk) begin
          errors++;
          $display("FAIL line_status cyc=%0d tag=%0d got hlen=%0d hlocked=%b want hlen=%0d hlocked=%b",
                   ec, es.tag, hlen, hlocked, es.hl, es.lk);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog cyc=%0d got timeout want finish", ec);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic push_out(input int tag, input logic [3:0] s, input logic [3*CW-1:0] vd, input logic nb);
    out_t e;
    e.tag  = tag;
    e.sync = s;
    e.nb   = nb;
`ifdef N64ADV_BLANK_ZERO_EN
    e.vd   = nb ? vd : '0;
`else
    e.vd   = vd;
`endif
    q_out.push_back(e);
  endtask

  task automatic push_st(input int tag, input int hl, input logic lk);
    st_t e;
    e.tag = tag;
    e.hl  = HW'(hl);
    e.lk  = lk;
    q_st.push_back(e);
  endtask

  // Drive one cycle; outputs for these inputs appear two edges later.
  task automatic drive(input logic [3:0] s, input logic [3*CW-1:0] vd, input logic pe, input logic nb);
    Sync_i = s;
    VD_i   = vd;
    pix_en = pe;
    push_out(ec + 2, s, vd, nb);
    @(posedge VCLK); #1;
  endtask

  task automatic do_reset(input int n);
    nVRST = 1'b0;
    for (int i = 0; i < n; i++) begin
      Sync_i = 4'hF;
      VD_i   = '1;
      pix_en = 1'b1;
      push_out(ec, 4'h0, '0, 1'b0);
      push_st(ec, 0, 1'b0);
      @(posedge VCLK); #1;
    end
    nVRST = 1'b1;
    push_out(ec + 1, 4'h0, '0, 1'b0);
    push_st(ec + 1, 0, 1'b0);
    $display("reset released at cycle %0d", ec);
  endtask

  task automatic idle(input int n, input logic [3*CW-1:0] vd);
    for (int i = 0; i < n; i++) drive(4'hF, vd, 1'b1, 1'b1);
  endtask

  task automatic set_cfg(input int sel);
    case (sel)
      0:       begin hs_c = 100;  ha_c = 640; vst_c = 1; va_c = 4;    end
      1:       begin hs_c = 10;   ha_c = 20;  vst_c = 2; va_c = 3;    end
      2:       begin hs_c = 10;   ha_c = 0;   vst_c = 2; va_c = 3;    end
      3:       begin hs_c = 10;   ha_c = 20;  vst_c = 0; va_c = 1023; end
      default: begin hs_c = 4000; ha_c = 200; vst_c = 0; va_c = 1023; end
    endcase
    cfg_hstart  = HW'(hs_c);
    cfg_hactive = HW'(ha_c);
    cfg_vstart  = VW'(vst_c);
    cfg_vactive = VW'(va_c);
  endtask

  // One video line of len strobes; with div=2 the strobe comes every other cycle.
  // vc, hl and lk are the hand-derived line counter, measured length and lock state.
  task automatic run_line(input int len, input int div, input bit vs, input int vc,
                          input int hl, input bit lk, input int cfg, input logic [3*CW-1:0] vd);
    int   last;
    int   hc;
    logic nh, nv, ncl, pe, hw, vw, nb;
    set_cfg(cfg);
    last = len * div + div - 1;
    for (int j = 0; j <= last; j++) begin
      nh  = (j >= 4);
      nv  = !vs;
      ncl = (j % 3 != 0);
      pe  = (j % div == 0);
      hc  = (j / div > 4095) ? 4095 : j / div;
      hw  = (hc >= hs_c) && (hc < hs_c + ha_c);
      vw  = (vc >= vst_c) && (vc < vst_c + va_c);
      nb  = lk ? (hw && vw) : (nh && nv);
      if (j == 0 || j == last) push_st(ec + 1, hl, lk);
      drive({nv, ncl, nh, nh & nv}, vd, pe, nb);
    end
    $display("line vcnt=%0d strobes=%0d div=%0d hlen_exp=%0d locked_exp=%0b", vc, len, div, hl, lk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_out.size() > 0 || q_st.size() > 0) && n < 20) begin
      @(posedge VCLK); #1;
      n++;
    end
    checks++;
    if (q_out.size() > 0 || q_st.size() > 0) begin
      errors++;
      $display("FAIL drain got pending out=%0d st=%0d want 0", q_out.size(), q_st.size());
    end
  endtask

  initial begin
    @(posedge VCLK); #1;
    set_cfg(0);
    do_reset(3);
    idle(4, 24'hA5A5A5);
    //       len  div vs vc  hlen  lk cfg vd
    run_line(1560, 1, 1, 0,    4,   0, 0, 24'hA5A5A5);
    run_line(1560, 1, 0, 1, 1560,   0, 0, 24'hA5A5A5);
    run_line(1560, 1, 0, 2, 1560,   0, 0, 24'hA5A5A5);
    run_line(1560, 1, 0, 3, 1560,   1, 0, 24'hA5A5A5);
    run_line(1559, 1, 0, 4, 1560,   1, 0, 24'hA5A5A5);
    run_line(8,    1, 0, 5, 1559,   0, 0, 24'hA5A5A5);
    run_line(8,    1, 0, 6,    8,   0, 0, 24'hA5A5A5);
    run_line(8,    1, 0, 7,    8,   0, 0, 24'hA5A5A5);
    run_line(8,    1, 0, 8,    8,   1, 0, 24'hA5A5A5);
    run_line(8,    1, 0, 9,    8,   1, 0, 24'hA5A5A5);
    drain();
    // Reset while locked and mid-line; lock must be rebuilt from scratch.
    do_reset(2);
    idle(4, 24'hFFFFFF);
    run_line(40,   1, 1, 0,    4,   0, 1, 24'hFFFFFF);
    run_line(40,   1, 0, 1,   40,   0, 1, 24'hFFFFFF);
    run_line(40,   1, 0, 2,   40,   0, 1, 24'hFFFFFF);
    run_line(40,   1, 0, 3,   40,   1, 1, 24'hFFFFFF);
    run_line(40,   1, 0, 4,   40,   1, 1, 24'hFFFFFF);
    run_line(40,   1, 0, 5,   40,   1, 1, 24'hFFFFFF);
    run_line(40,   1, 0, 6,   40,   1, 1, 24'hFFFFFF);
    run_line(40,   1, 0, 7,   40,   1, 1, 24'hFFFFFF);
    run_line(40,   1, 1, 0,   40,   1, 1, 24'hFFFFFF);
    run_line(40,   2, 0, 1,   40,   1, 1, 24'h5A3C96);
    run_line(40,   2, 0, 2,   40,   1, 1, 24'h5A3C96);
    run_line(40,   1, 0, 3,   40,   1, 1, 24'hFFFFFF);
    run_line(40,   1, 0, 4,   40,   1, 2, 24'hFFFFFF);
    run_line(40,   1, 0, 5,   40,   1, 1, 24'hFFFFFF);
    run_line(40,   1, 0, 6,   40,   1, 3, 24'hFFFFFF);
    run_line(5000, 1, 0, 7,   40,   1, 4, 24'h123456);
    run_line(40,   1, 0, 8, 4095,   0, 4, 24'hFFFFFF);
    run_line(40,   1, 0, 9,   40,   0, 4, 24'hFFFFFF);
    run_line(8,    1, 0, 10,  40,   0, 4, 24'hFFFFFF);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
